// File: rtl/mtx_sig_pkg.sv
// Shared constants and quadrant-folding helper for the multi-tone sin/cos generator.
package mtx_sig_pkg;

  localparam int unsigned LUT_ADDR_W   = 10;
  localparam int unsigned QTR_W        = LUT_ADDR_W - 2;
  localparam int unsigned IDX_W        = QTR_W + 1;
  localparam int unsigned QTR_N        = (1 << QTR_W) + 1;
  // Peak amplitude is 2^(SIN_COS_WIDTH - AMP_HEADROOM).
  localparam int unsigned AMP_HEADROOM = 2;

  typedef struct packed {
    logic             neg;
    logic [IDX_W-1:0] idx;
  } fold_t;

  // Map a full-circle address onto the quarter-wave table (odd quadrants mirror, upper half negates).
  function automatic fold_t quad_fold(input logic [LUT_ADDR_W-1:0] addr);
    fold_t            f;
    logic [IDX_W-1:0] off;
    off   = {1'b0, addr[QTR_W-1:0]};
    f.neg = addr[LUT_ADDR_W-1];
    f.idx = addr[QTR_W] ? (IDX_W'(1 << QTR_W) - off) : off;
    return f;
  endfunction

endpackage

// File: rtl/mtx_sincos_lut.sv
// Quarter-wave sin/cos ROM with quadrant folding and a registered, enable-gated output.
module mtx_sincos_lut
  import mtx_sig_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic [LUT_ADDR_W-1:0]        addr,
  output logic signed [W-1:0]          sin,
  output logic signed [W-1:0]          cos
);

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = real'(1 << (W - AMP_HEADROOM));

  function automatic int quarter_sin(input int i);
    return $rtoi(AMP * $sin(PI * real'(i) / real'(2 * (QTR_N - 1))) + 0.5);
  endfunction

  logic signed [W-1:0] rom [QTR_N];

  for (genvar g = 0; g < QTR_N; g++) begin : g_rom
    assign rom[g] = W'(quarter_sin(g));
  end

  fold_t               fs;
  fold_t               fc;
  logic signed [W-1:0] sin_nxt;
  logic signed [W-1:0] cos_nxt;

  // cos is sin a quarter turn ahead
  always_comb begin
    fs      = quad_fold(addr);
    fc      = quad_fold(addr + LUT_ADDR_W'(1 << QTR_W));
    sin_nxt = fs.neg ? -rom[fs.idx] : rom[fs.idx];
    cos_nxt = fc.neg ? -rom[fc.idx] : rom[fc.idx];
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      sin <= '0;
      cos <= '0;
    end else if (en) begin
      sin <= sin_nxt;
      cos <= cos_nxt;
    end
  end

endmodule

// File: rtl/mtx_sig_gen.sv
// Stepped-frequency quadrature tone generator; MTX_SIG_PH_SHIFT_EN enables per-symbol start-phase advance.
module mtx_sig_gen
  import mtx_sig_pkg::*;
#(
  parameter int unsigned SIN_COS_WIDTH = 16,
  parameter int unsigned PHASE_WIDTH   = 24,
  parameter int unsigned NSYMB_WIDTH   = 16,
  parameter int unsigned NSIG          = 32768,
  parameter int unsigned NSYMB         = 512,
  parameter int unsigned NLOC_PER_SYNC = 7,
  parameter int          DPH_INC       = 16384,
  parameter int          START_PH_INC  = -4185088,
  parameter int unsigned START_PH      = 0,
  parameter int          NPH_SHIFT     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            srst,
  input  logic                            phase_tvalid,
  input  logic                            phase_tlast,
  input  logic                            out_tready,
  output logic                            sync_ready,
  output logic signed [SIN_COS_WIDTH-1:0] sin,
  output logic signed [SIN_COS_WIDTH-1:0] cos,
  output logic [PHASE_WIDTH-1:0]          ph,
  output logic [PHASE_WIDTH-1:0]          ph_start,
  output logic [PHASE_WIDTH-1:0]          sigN,
  output logic [NSYMB_WIDTH-1:0]          symbN
);

  localparam int unsigned PW    = PHASE_WIDTH;
  localparam int unsigned LOC_W = (NLOC_PER_SYNC > 1) ? $clog2(NLOC_PER_SYNC) : 1;

  localparam logic [PW-1:0]          INC0      = PW'(START_PH_INC);
  localparam logic [PW-1:0]          PH0       = PW'(START_PH);
  localparam logic [PW-1:0]          DPH       = PW'(DPH_INC);
  localparam logic [PW-1:0]          PH_SHIFT  = PW'(NPH_SHIFT);
  localparam logic [PW-1:0]          SIG_LAST  = PW'(NSIG - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);
  localparam logic [LOC_W-1:0]       LOC_LAST  = LOC_W'(NLOC_PER_SYNC - 1);

`ifdef MTX_SIG_PH_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic                   beat;
  logic [PW-1:0]          ph_inc;
  logic [LOC_W-1:0]       loc;
  logic [PW-1:0]          ph_start_adv;
  logic [PW-1:0]          ph_nxt;
  logic [PW-1:0]          ph_start_nxt;
  logic [PW-1:0]          ph_inc_nxt;
  logic [PW-1:0]          sig_nxt;
  logic [NSYMB_WIDTH-1:0] symb_nxt;
  logic [LOC_W-1:0]       loc_nxt;
  logic                   sync_nxt;

  assign beat = phase_tvalid && out_tready;

  // Sample / symbol / sweep sequencing; nothing moves without a beat
  always_comb begin
    ph_nxt       = ph;
    ph_start_nxt = ph_start;
    ph_inc_nxt   = ph_inc;
    sig_nxt      = sigN;
    symb_nxt     = symbN;
    loc_nxt      = loc;
    sync_nxt     = 1'b0;
    ph_start_adv = SHIFT_EN ? (ph_start + PH_SHIFT) : PH0;
    if (beat) begin
      if (sigN == SIG_LAST || phase_tlast) begin
        sig_nxt      = '0;
        ph_nxt       = ph_start_adv;
        ph_start_nxt = ph_start_adv;
        ph_inc_nxt   = ph_inc + DPH;
        symb_nxt     = symbN + NSYMB_WIDTH'(1);
        if (symbN == SYMB_LAST) begin
          symb_nxt     = '0;
          ph_inc_nxt   = INC0;
          ph_nxt       = PH0;
          ph_start_nxt = PH0;
          loc_nxt      = loc + LOC_W'(1);
          if (loc == LOC_LAST) begin
            loc_nxt  = '0;
            sync_nxt = 1'b1;
          end
        end
      end else begin
        ph_nxt  = ph + ph_inc;
        sig_nxt = sigN + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || srst) begin
      ph         <= PH0;
      ph_start   <= PH0;
      ph_inc     <= INC0;
      sigN       <= '0;
      symbN      <= '0;
      loc        <= '0;
      sync_ready <= 1'b0;
    end else begin
      ph         <= ph_nxt;
      ph_start   <= ph_start_nxt;
      ph_inc     <= ph_inc_nxt;
      sigN       <= sig_nxt;
      symbN      <= symb_nxt;
      loc        <= loc_nxt;
      sync_ready <= sync_nxt;
    end
  end

  mtx_sincos_lut #(
    .W (SIN_COS_WIDTH)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .clr   (srst),
    .en    (beat),
    .addr  (ph[PW-1 -: LUT_ADDR_W]),
    .sin   (sin),
    .cos   (cos)
  );

endmodule

// File: tb/tb_mtx_sig_gen.sv
// Self-checking bench for mtx_sig_gen: vector table, scoreboard queues and multi-cycle corner sequences.
module tb_mtx_sig_gen;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic [23:0] ph;
    logic [23:0] inc;
    logic [23:0] sig;
    logic [15:0] symb;
    int          loc;
    logic        sync;
    int          sn;
    int          cs;
  } mdl_t;

  typedef struct {
    int          nsig;
    int          nsymb;
    int          nloc;
    logic [23:0] dph;
    logic [23:0] inc0;
  } cfg_t;

  typedef struct {
    logic        v;
    logic        r;
    logic        l;
    logic        s;
    logic [23:0] ph;
    logic [23:0] sig;
    logic [15:0] symb;
    logic        sync;
  } vec_t;

  logic clk = 1'b0;
  logic reset, srst, tvalid, tlast, tready, b_valid;

  logic               sync_a, sync_b;
  logic signed [15:0] sin_a, cos_a, sin_b, cos_b;
  logic [23:0]        ph_a, phs_a, sig_a, ph_b, phs_b, sig_b;
  logic [15:0]        symb_a, symb_b;

  int   n_cmp = 0;
  int   n_err = 0;
  mdl_t ma, mb;
  cfg_t ca, cb;
  mdl_t qa[$];
  mdl_t qb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  mtx_sig_gen #(
    .SIN_COS_WIDTH(16), .PHASE_WIDTH(24), .NSYMB_WIDTH(16), .NSIG(4), .NSYMB(3),
    .NLOC_PER_SYNC(2), .DPH_INC(16), .START_PH_INC(8), .START_PH(0), .NPH_SHIFT(0)
  ) u_dut (
    .clk(clk), .reset(reset), .srst(srst), .phase_tvalid(tvalid), .phase_tlast(tlast),
    .out_tready(tready), .sync_ready(sync_a), .sin(sin_a), .cos(cos_a), .ph(ph_a),
    .ph_start(phs_a), .sigN(sig_a), .symbN(symb_a)
  );

  // Second instance sweeps coarse phase steps to exercise every LUT quadrant
  mtx_sig_gen #(
    .SIN_COS_WIDTH(16), .PHASE_WIDTH(24), .NSYMB_WIDTH(16), .NSIG(16), .NSYMB(2),
    .NLOC_PER_SYNC(2), .DPH_INC(32'h80000), .START_PH_INC(32'h100000), .START_PH(0), .NPH_SHIFT(0)
  ) u_lut (
    .clk(clk), .reset(reset), .srst(1'b0), .phase_tvalid(b_valid), .phase_tlast(1'b0),
    .out_tready(1'b1), .sync_ready(sync_b), .sin(sin_b), .cos(cos_b), .ph(ph_b),
    .ph_start(phs_b), .sigN(sig_b), .symbN(symb_b)
  );

  function automatic int ref_wave(input logic [23:0] p, input bit is_cos);
    real a;
    real v;
    a = 2.0 * PI * real'(p[23:14]) / 1024.0;
    v = 16384.0 * (is_cos ? $cos(a) : $sin(a));
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input cfg_t c, input bit rst,
                                    input bit sr, input bit beat, input bit last);
    mdl_t n;
    n = m;
    n.sync = 1'b0;
    if (rst || sr) begin
      n.ph = '0; n.inc = c.inc0; n.sig = '0; n.symb = '0; n.loc = 0; n.sn = 0; n.cs = 0;
    end else if (beat) begin
      n.sn = ref_wave(m.ph, 1'b0);
      n.cs = ref_wave(m.ph, 1'b1);
      if (m.sig == 24'(c.nsig - 1) || last) begin
        n.sig = '0; n.ph = '0; n.inc = m.inc + c.dph; n.symb = m.symb + 16'd1;
        if (m.symb == 16'(c.nsymb - 1)) begin
          n.symb = '0; n.inc = c.inc0; n.loc = m.loc + 1;
          if (m.loc == c.nloc - 1) begin
            n.loc = 0; n.sync = 1'b1;
          end
        end
      end else begin
        n.ph  = m.ph + m.inc;
        n.sig = m.sig + 24'd1;
      end
    end
    return n;
  endfunction

  function automatic vec_t mk(input bit v, input bit r, input bit l, input bit s,
                              input int p, input int sg, input int sy, input bit sc);
    vec_t t;
    t.v = v; t.r = r; t.l = l; t.s = s;
    t.ph = 24'(p); t.sig = 24'(sg); t.symb = 16'(sy); t.sync = sc;
    return t;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp);
    n_cmp++;
    if (act > exp + 1 || act < exp - 1) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d+-1 (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push model predictions for this cycle's stimulus, clock, then score both instances
  task automatic cycle();
    mdl_t ea;
    mdl_t eb;
    ma = mdl_next(ma, ca, !reset, srst, tvalid && tready, tlast);
    qa.push_back(ma);
    mb = mdl_next(mb, cb, !reset, 1'b0, b_valid, 1'b0);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("a.ph", ph_a, ea.ph);
    chk("a.sigN", sig_a, ea.sig);
    chk("a.symbN", symb_a, ea.symb);
    chk("a.sync_ready", sync_a, ea.sync);
    chk("a.ph_start", phs_a, 0);
    chk_tol("a.sin", int'(sin_a), ea.sn);
    chk_tol("a.cos", int'(cos_a), ea.cs);
    chk("b.ph", ph_b, eb.ph);
    chk("b.symbN", symb_b, eb.symb);
    chk_tol("b.sin", int'(sin_b), eb.sn);
    chk_tol("b.cos", int'(cos_b), eb.cs);
  endtask

  initial begin
    int cnt;
    ca = '{nsig: 4, nsymb: 3, nloc: 2, dph: 24'd16, inc0: 24'd8};
    cb = '{nsig: 16, nsymb: 2, nloc: 2, dph: 24'h080000, inc0: 24'h100000};

    // Sweep trace, stall, early tlast and soft restart
    tbl.push_back(mk(1,1,0,0,   8,1,0,0)); tbl.push_back(mk(1,1,0,0,  16,2,0,0));
    tbl.push_back(mk(1,1,0,0,  24,3,0,0)); tbl.push_back(mk(1,1,0,0,   0,0,1,0));
    tbl.push_back(mk(1,1,0,0,  24,1,1,0)); tbl.push_back(mk(1,1,0,0,  48,2,1,0));
    tbl.push_back(mk(1,1,0,0,  72,3,1,0)); tbl.push_back(mk(1,1,0,0,   0,0,2,0));
    tbl.push_back(mk(1,1,0,0,  40,1,2,0)); tbl.push_back(mk(1,1,0,0,  80,2,2,0));
    tbl.push_back(mk(1,1,0,0, 120,3,2,0)); tbl.push_back(mk(1,1,0,0,   0,0,0,0));
    tbl.push_back(mk(1,1,0,0,   8,1,0,0)); tbl.push_back(mk(1,1,0,0,  16,2,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,0, 16,2,0,0));
    tbl.push_back(mk(0,1,1,0,  16,2,0,0)); tbl.push_back(mk(1,1,0,0,  24,3,0,0));
    tbl.push_back(mk(1,1,0,0,   0,0,1,0)); tbl.push_back(mk(1,1,1,0,   0,0,2,0));
    tbl.push_back(mk(1,1,0,0,  40,1,2,0)); tbl.push_back(mk(1,1,0,0,  80,2,2,0));
    tbl.push_back(mk(1,1,0,1,   0,0,0,0));

    reset = 1'b0; srst = 1'b0; tvalid = 1'b1; tready = 1'b1; tlast = 1'b0; b_valid = 1'b0;
    ma = '{ph: '0, inc: '0, sig: '0, symb: '0, loc: 0, sync: 1'b0, sn: 0, cs: 0};
    mb = ma;
    for (int i = 0; i < 3; i++) cycle();
    chk("rst.ph", ph_a, 0);
    chk("rst.sin", int'(sin_a), 0);
    chk("rst.cos", int'(cos_a), 0);
    chk("rst.sync_ready", sync_a, 0);

    reset = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      tvalid = tbl[i].v; tready = tbl[i].r; tlast = tbl[i].l; srst = tbl[i].s;
      cycle();
      chk($sformatf("vec%0d.ph", i), ph_a, tbl[i].ph);
      chk($sformatf("vec%0d.sigN", i), sig_a, tbl[i].sig);
      chk($sformatf("vec%0d.symbN", i), symb_a, tbl[i].symb);
      chk($sformatf("vec%0d.sync", i), sync_a, tbl[i].sync);
      if (i == 0) begin
        chk("first.cos", int'(cos_a), 16384);
        chk("first.sin", int'(sin_a), 0);
      end
    end

    // After the soft restart the sync pulse must be a full two sweeps away, then repeat every two sweeps
    srst = 1'b0; tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      while (cnt < 60) begin
        cycle();
        cnt++;
        if (sync_a) break;
      end
      chk($sformatf("sync%0d.beats", p), cnt, 24);
    end
    cycle();
    chk("sync.one_cycle", sync_a, 0);

    // LUT quadrant points on the coarse-step instance
    tvalid = 1'b0;
    b_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (k == 5) begin
        chk_tol("lut.sin_90", int'(sin_b), 16384);
        chk_tol("lut.cos_90", int'(cos_b), 0);
      end
      if (k == 9) begin
        chk_tol("lut.cos_180", int'(cos_b), -16384);
        chk_tol("lut.sin_180", int'(sin_b), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mtx_sig_gen.md
Name: mtx_sig_gen

Overview:
Stepped-frequency quadrature tone generator for the ANC multi-tone TX path. A phase accumulator sweeps NSYMB symbols of NSIG samples each. The phase increment rises by DPH_INC every symbol, and the generator emits 1-cycle-registered sin/cos samples through a LUT. After NLOC_PER_SYNC complete sweeps it pulses sync_ready so the controller can insert a sync preamble.

Parameters:
SIN_COS_WIDTH, 16, sin/cos sample width (signed)
PHASE_WIDTH, 24, phase accumulator and sigN width
NSYMB_WIDTH, 16, symbN width
NSIG, 32768, samples per symbol
NSYMB, 512, symbols per sweep
NLOC_PER_SYNC, 7, sweeps between sync_ready pulses
DPH_INC, 16384, increment step per symbol
START_PH_INC, -4185088 (24-bit two's complement), increment of symbol 0
START_PH, 0, initial phase and initial ph_start
NPH_SHIFT, 0, per-symbol ph_start advance (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
srst  in  1  synchronous active-high soft restart
phase_tvalid  in  1  input beat valid
phase_tlast  in  1  early symbol end, honoured only on an accepted beat
out_tready  in  1  downstream ready
sync_ready  out  1  one-cycle pulse after NLOC_PER_SYNC sweeps
sin  out  SIN_COS_WIDTH  signed sine sample
cos  out  SIN_COS_WIDTH  signed cosine sample
ph  out  PHASE_WIDTH  current phase
ph_start  out  PHASE_WIDTH  symbol start phase
sigN  out  PHASE_WIDTH  sample index within symbol
symbN  out  NSYMB_WIDTH  symbol index

Behaviour:
- Beat: a beat is a cycle with phase_tvalid && out_tready. All state advances only on a beat; with no beat, every register holds.
- Reset (reset==0) or srst==1: ph=START_PH, ph_start=START_PH, ph_inc=START_PH_INC, sigN=0, symbN=0, loc=0, sync_ready=0, sin=0, cos=0. reset has priority over srst. While srst is held, state stays at these values.
- Per beat, non-boundary: ph += ph_inc (mod 2^PHASE_WIDTH); sigN += 1.
- Symbol boundary (sigN==NSIG-1, or phase_tlast on the beat): sigN=0; ph=ph_start_next; ph_inc += DPH_INC; symbN += 1.
- Sweep end (boundary with symbN==NSYMB-1): symbN=0; ph_inc=START_PH_INC; ph=ph_start=START_PH; loc += 1.
- Sync (sweep end with loc==NLOC_PER_SYNC-1): loc=0; sync_ready=1 on the next cycle, for exactly one cycle. Otherwise sync_ready=0.
- sin/cos: LUT of the top 10 bits of ph. Peak amplitude 2^(SIN_COS_WIDTH-2), i.e. 16384. Output registered: sin/cos reflect the ph of the previous beat (1-beat latency). Held while stalled.
- Arithmetic: all phase and increment arithmetic unsigned modulo 2^PHASE_WIDTH; negative increments wrap naturally.

Optional Feature:
Macro MTX_SIG_PH_SHIFT_EN.
- Defined: ph_start_next = ph_start + NPH_SHIFT at each symbol boundary, and ph_start is updated to it. Reset to START_PH at sweep end.
- Undefined: ph_start is constant START_PH, and ph_start_next = START_PH.

Decomposition:
- Package mtx_sig_pkg: LUT_ADDR_W=10, amplitude constant, quadrant-fold helper function.
- One sub-module, mtx_sincos_lut: quarter-wave ROM built at elaboration, registered output, quadrant folding for sin and cos.

Test Plan:
Bench parameters: NSIG=4, NSYMB=3, DPH_INC=16, START_PH_INC=8, START_PH=0, NLOC_PER_SYNC=2, tvalid=tready=1.
- Reset: hold reset=0 for 3 cycles -> ph=0, sigN=0, symbN=0, sin=0, cos=0, sync_ready=0. One beat after release -> cos=16384, sin=0.
- Sweep trace: continuous beats -> ph sequence 0,8,16,24 | 0,24,48,72 | 0,40,80,120 | 0,8 … with symbN 0→1→2→0.
- Sync: continuous beats -> sync_ready high for exactly one cycle, the cycle after the 24th beat. Next pulse 24 beats later.
- Stall: out_tready=0 for 5 cycles mid-symbol -> ph, sigN, symbN, sin, cos unchanged. Resume continues the sequence with no skipped value.
- srst mid-sweep (symbN=2): one-cycle srst -> ph=0, symbN=0, sigN=0, loc cleared. No sync_ready until 24 beats later.
- LUT (PHASE_WIDTH=24): ph=0x400000 -> sin=16384±1, cos=0±1. ph=0x800000 -> cos=-16384±1.
